// File: rtl/bit_serializer.sv
// bit_serializer: accepts WIDTH-bit words over a valid/ready handshake and
// shifts them out MSB-first on sout, one bit per clock. A one-word hold
// register lets the next word queue up so back-to-back frames have no gap.
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit
// after the LSB of every frame (frame length WIDTH+1 instead of WIDTH).
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_busy;

  logic [0:0]       w_nstate;
  logic [WIDTH-1:0] w_nshift;
  logic [CNT_W-1:0] w_ncnt;
  logic [WIDTH-1:0] w_nhold;
  logic             w_nhold_full;
  logic             w_load;
  logic [WIDTH-1:0] w_load_word;
  logic             w_accept;
  logic             w_last;
  logic             w_fill;

  assign din_ready  = !r_hold_full && !reset;
  assign w_accept   = din_valid && din_ready;
  assign w_last     = (r_cnt == LAST_CNT);
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = r_busy;

`ifdef SERIALIZER_PARITY_EN
  logic r_par;

  // Capture even parity of each word as it enters the shift register; it is
  // shifted in behind the data so it reaches the MSB after the LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^w_load_word;
    end
  end

  assign w_fill = r_par;
`else
  assign w_fill = 1'b0;
`endif

  // Next-state logic: start, advance, chain or end a frame; queue a word.
  always_comb begin
    w_nstate     = r_state;
    w_nshift     = r_shift;
    w_ncnt       = r_cnt;
    w_nhold      = r_hold;
    w_nhold_full = r_hold_full;
    w_load       = 1'b0;
    w_load_word  = din;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load   = 1'b1;
          w_ncnt   = '0;
          w_nstate = S_SHIFT;
        end
      end
      default: begin
        if (w_last) begin
          w_ncnt = '0;
          if (r_hold_full) begin
            // Queued word follows immediately: no idle bit between frames.
            w_load       = 1'b1;
            w_load_word  = r_hold;
            w_nhold_full = 1'b0;
          end else if (w_accept) begin
            w_load = 1'b1;
          end else begin
            w_nstate = S_IDLE;
            w_nshift = '0;
          end
        end else begin
          w_nshift = {r_shift[WIDTH-2:0], w_fill};
          w_ncnt   = r_cnt + CNT_W'(1);
          if (w_accept) begin
            w_nhold      = din;
            w_nhold_full = 1'b1;
          end
        end
      end
    endcase
    if (w_load) begin
      w_nshift = w_load_word;
    end
  end

  // State and output registers; outputs are computed from next-state values
  // so a word accepted at an edge shows its MSB right after that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_shift      <= w_nshift;
      r_cnt        <= w_ncnt;
      r_hold       <= w_nhold;
      r_hold_full  <= w_nhold_full;
      r_sout       <= (w_nstate == S_SHIFT) && w_nshift[WIDTH-1];
      r_sout_valid <= (w_nstate == S_SHIFT);
      r_busy       <= (w_nstate == S_SHIFT) || w_nhold_full;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer (WIDTH=8). Builds with or without
// SERIALIZER_PARITY_EN; expected frames follow the selected build. sout also
// feeds a Mealy "101" (overlapping) detector whose per-bit output is compared
// against a history-window reference of the expected bit stream.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  bit_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream Mealy sequence detector for "101", fed by sout.
  logic [1:0] det_st;
  logic       det_out;
  assign det_out = (det_st == 2'd2) && sout && sout_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      det_st <= 2'd0;
    end else if (sout_valid) begin
      case (det_st)
        2'd0:    det_st <= sout ? 2'd1 : 2'd0;
        2'd1:    det_st <= sout ? 2'd1 : 2'd2;
        default: det_st <= sout ? 2'd1 : 2'd0;
      endcase
    end
  end

  // Reference for the detector: last two expected bits and how many seen.
  logic [1:0] ref_hist = 2'b00;
  int         ref_len  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] w, input int i);
    if (i < W) return w[W-1-i];
    return ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one expected frame bit on the serial output and the detector.
  task automatic chk_bit(input string tag, input logic b);
    logic exp_det;
    exp_det = (ref_len >= 2) && (ref_hist == 2'b10) && b;
    chk($sformatf("%s.valid", tag), 32'(sout_valid), 32'd1);
    chk($sformatf("%s.sout", tag), 32'(sout), 32'(b));
    chk($sformatf("%s.det", tag), 32'(det_out), 32'(exp_det));
    ref_hist = {ref_hist[0], b};
    ref_len++;
  endtask

  task automatic chk_idle(input string tag);
    chk($sformatf("%s.valid", tag), 32'(sout_valid), 32'd0);
    chk($sformatf("%s.sout", tag), 32'(sout), 32'd0);
    chk($sformatf("%s.busy", tag), 32'(busy), 32'd0);
  endtask

  // Push one word from IDLE and check its whole frame.
  task automatic single_frame(input logic [7:0] w, input string tag);
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < F; i++) begin
      chk_bit($sformatf("%s.b%0d", tag, i), fbit(w, i));
      chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
      tick();
    end
    chk_idle($sformatf("%s.end", tag));
  endtask

  initial begin
    logic [7:0] words [3];
    logic exp_rdy;

    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst.ready", 32'(din_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 32'(din_ready), 32'd1);
    tick();
    chk_idle("rst.idle");

    // Single frames, including the parity examples.
    single_frame(8'hA5, "a5");
    tick();
    single_frame(8'h07, "w07");
    tick();

    // Two words back to back: 16 (or 18) contiguous bits, no gap.
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    din = words[0];
    din_valid = 1'b1;
    tick();
    din = words[1];
    for (int i = 0; i < 2 * F; i++) begin
      chk_bit($sformatf("b2b.b%0d", i), fbit(words[i / F], i % F));
      tick();
      if (i == 0) din_valid = 1'b0;
    end
    chk_idle("b2b.end");
    tick();

    // Hold full: third word is blocked until the first frame's last bit,
    // and junk on din while blocked must be ignored.
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h5A;
    din = words[0];
    din_valid = 1'b1;
    tick();
    din = words[1];
    for (int i = 0; i < 3 * F; i++) begin
      exp_rdy = (i == 0) || (i == F) || (i >= 2 * F);
      chk_bit($sformatf("hold.b%0d", i), fbit(words[i / F], i % F));
      chk($sformatf("hold.ready%0d", i), 32'(din_ready), 32'(exp_rdy));
      tick();
      if (i == 0) din = 8'hC3;
      if (i == F - 1) din = words[2];
      if (i == F) din_valid = 1'b0;
    end
    chk_idle("hold.end");
    tick();

    // Reset at bit 4 of 8'hFF with 8'h81 held: frame aborted, hold dropped.
    din = 8'hFF;
    din_valid = 1'b1;
    tick();
    din = 8'h81;
    for (int i = 0; i <= 4; i++) begin
      chk_bit($sformatf("abort.b%0d", i), fbit(8'hFF, i));
      if (i == 4) begin
        reset = 1'b1;
        #1;
        chk("abort.ready_in_rst", 32'(din_ready), 32'd0);
      end
      tick();
      if (i == 0) din_valid = 1'b0;
    end
    chk_idle("abort.after");
    reset = 1'b0;
    ref_hist = 2'b00;
    ref_len = 0;
    #1;
    chk("abort.ready", 32'(din_ready), 32'd1);
    for (int i = 0; i < F + 4; i++) begin
      tick();
      chk($sformatf("abort.quiet%0d", i), 32'(sout_valid), 32'd0);
    end

    // Detector after reset: fresh stream.
    single_frame(8'hAD, "ad");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
